// File: rtl/nw_sw_alloc_rr_pkg.sv
// Shared router package: port count default, port-index and crossbar-select types.
package nw_sw_alloc_rr_pkg;
  localparam int N_PORTS = 5;
  localparam int PORT_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef logic [PORT_W-1:0]               port_idx_t;
  // Crossbar select matrix: [output][input], one-hot per output row.
  typedef logic [N_PORTS-1:0][N_PORTS-1:0] sel_mat_t;
endpackage

// File: rtl/nw_sw_alloc_rr_arb.sv
// N-way round-robin arbiter: purely combinational, search starts at ptr_i and wraps.
// Holds no state; the pointer is owned by the allocator.
module nw_rr_arbiter #(
  parameter  int N  = 5,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o
);

  logic          found;
  logic [PW-1:0] cand;

  // First requester at or after ptr_i (modulo N) wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(ptr_i) + k) % N);
      if (!found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nw_sw_alloc_rr.sv
// Switch allocator: one round-robin arbiter per output, zero-latency grants.
// Optional wormhole packet locking under `NW_SW_ALLOC_PKT_LOCK_EN.
module nw_sw_alloc_rr
  import nw_sw_alloc_rr_pkg::*;
#(
  parameter  int N  = N_PORTS,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N-1:0][N-1:0] req_i,
  input  logic [N-1:0]        req_tail_i,
  input  logic [N-1:0]        out_ready_i,
  output logic [N-1:0]        gnt_o,
  output logic [N-1:0][N-1:0] xbar_select_o,
  output logic [N-1:0]        out_valid_o
);

  logic [N-1:0][N-1:0]  req_lo;   // [input][output], lowest set bit only
  logic [N-1:0][N-1:0]  cand;     // [output][input], eligible requesters
  logic [N-1:0][N-1:0]  win;      // [output][input], arbiter choice
  logic [N-1:0][PW-1:0] widx;
  logic [N-1:0][PW-1:0] ptr_q, ptr_d;

  // Keep only the lowest-index request per input so it competes for one output.
  always_comb begin
    for (int i = 0; i < N; i++)
      req_lo[i] = req_i[i] & (~req_i[i] + N'(1));
  end

`ifdef NW_SW_ALLOC_PKT_LOCK_EN
  logic [N-1:0]         lock_q, lock_d;
  logic [N-1:0][PW-1:0] owner_q, owner_d;

  // Transpose to per-output columns; a locked output only sees its owner.
  always_comb begin
    for (int o = 0; o < N; o++)
      for (int i = 0; i < N; i++)
        cand[o][i] = req_lo[i][o] && (!lock_q[o] || (owner_q[o] == PW'(i)));
  end

  // Non-tail grant takes the lock, tail grant releases it; idle owner holds it.
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    for (int o = 0; o < N; o++) begin
      if (out_valid_o[o]) begin
        lock_d[o]  = !req_tail_i[widx[o]];
        owner_d[o] = widx[o];
      end
    end
  end

  // Lock state register; reset drops any packet in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q  <= '0;
      owner_q <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ^req_tail_i;

  // Transpose to per-output columns; every flit arbitrates independently.
  always_comb begin
    for (int o = 0; o < N; o++)
      for (int i = 0; i < N; i++)
        cand[o][i] = req_lo[i][o];
  end
`endif

  for (genvar o = 0; o < N; o++) begin : g_arb
    nw_rr_arbiter #(.N(N)) u_arb (
      .req_i (cand[o]),
      .ptr_i (ptr_q[o]),
      .gnt_o (win[o]),
      .idx_o (widx[o])
    );
  end

  // Qualify arbiter choice with ready and reset; gnt is the OR of each select column.
  always_comb begin
    gnt_o         = '0;
    xbar_select_o = '0;
    out_valid_o   = '0;
    for (int o = 0; o < N; o++) begin
      out_valid_o[o]   = !rst_i && out_ready_i[o] && (|win[o]);
      xbar_select_o[o] = out_valid_o[o] ? win[o] : '0;
      gnt_o            = gnt_o | xbar_select_o[o];
    end
  end

  // Pointer moves just past the winner on a grant, holds otherwise.
  always_comb begin
    ptr_d = ptr_q;
    for (int o = 0; o < N; o++)
      if (out_valid_o[o])
        ptr_d[o] = (widx[o] == PW'(N - 1)) ? '0 : widx[o] + PW'(1);
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: tb/tb_nw_sw_alloc_rr.sv
// Self-checking bench for nw_sw_alloc_rr (N=5). Expectations depend on
// NW_SW_ALLOC_PKT_LOCK_EN where packet locking changes the outcome.
module tb_nw_sw_alloc_rr;
  localparam int N = 5;
  localparam int X = -1;  // no winner on this output

  typedef struct packed {
    logic                rst;
    logic [N-1:0][N-1:0] req;
    logic [N-1:0]        tail;
    logic [N-1:0]        rdy;
    logic [N-1:0]        gnt;
    logic [N-1:0]        vld;
    logic [N-1:0][N-1:0] xb;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0][N-1:0] req;
  logic [N-1:0]        req_tail;
  logic [N-1:0]        out_ready;
  logic [N-1:0]        gnt;
  logic [N-1:0][N-1:0] xbar_select;
  logic [N-1:0]        out_valid;

  int n_run  = 0;
  int n_fail = 0;
  vec_t tbl[$];
  vec_t sb[$];

  nw_sw_alloc_rr #(.N(N)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .req_tail_i    (req_tail),
    .out_ready_i   (out_ready),
    .gnt_o         (gnt),
    .xbar_select_o (xbar_select),
    .out_valid_o   (out_valid)
  );

  always #5 clk = ~clk;

  // Build a record: per-input request rows, then the expected winner per output.
  function automatic vec_t mk(input logic r, input logic [N-1:0] r0, r1, r2, r3, r4,
                              input logic [N-1:0] tl, rd,
                              input int w0, w1, w2, w3, w4);
    vec_t v;
    int   w[N];
    v = '0;
    v.rst = r;
    v.req[0] = r0; v.req[1] = r1; v.req[2] = r2; v.req[3] = r3; v.req[4] = r4;
    v.tail = tl;
    v.rdy  = rd;
    w = '{w0, w1, w2, w3, w4};
    for (int o = 0; o < N; o++) begin
      if (w[o] >= 0) begin
        v.xb[o][w[o]] = 1'b1;
        v.vld[o]      = 1'b1;
        v.gnt[w[o]]   = 1'b1;
      end
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, exp_v, input int idx);
    n_run++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp_v);
    end
  endtask

  // Drive one cycle, push expectation, pop and compare mid-cycle.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(posedge clk); #1;
    rst       = v.rst;
    req       = v.req;
    req_tail  = v.tail;
    out_ready = v.rdy;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk("gnt",       32'(gnt),         32'(e.gnt), idx);
    chk("out_valid", 32'(out_valid),   32'(e.vld), idx);
    chk("xbar",      32'(xbar_select), 32'(e.xb),  idx);
  endtask

  initial begin
    logic [N-1:0] A;
    A = '1;
    rst = 1'b1; req = '0; req_tail = '1; out_ready = '1;
    repeat (2) @(posedge clk);

    // reset forces outputs low even with requests present
    tbl.push_back(mk(1, 5'b00100, 0, 0, 5'b00100, 0, A, A, X, X, X, X, X));
    // fresh after reset: ptr2=0 -> input 0, then ptr2=1 -> input 3
    tbl.push_back(mk(0, 5'b00100, 0, 0, 5'b00100, 0, A, A, X, X, 0, X, X));
    tbl.push_back(mk(0, 5'b00100, 0, 0, 5'b00100, 0, A, A, X, X, 3, X, X));
    // round robin on output 1 among inputs 0,1,4
    tbl.push_back(mk(0, 5'b00010, 5'b00010, 0, 0, 5'b00010, A, A, X, 0, X, X, X));
    tbl.push_back(mk(0, 5'b00010, 5'b00010, 0, 0, 5'b00010, A, A, X, 1, X, X, X));
    tbl.push_back(mk(0, 5'b00010, 5'b00010, 0, 0, 5'b00010, A, A, X, 4, X, X, X));
    tbl.push_back(mk(0, 5'b00010, 5'b00010, 0, 0, 5'b00010, A, A, X, 0, X, X, X));
    // backpressure on output 3: ptr3 -> 3, stall, then 4 wins (ptr held), then 2
    tbl.push_back(mk(0, 0, 0, 5'b01000, 0, 0, A, A, X, X, X, 2, X));
    tbl.push_back(mk(0, 0, 0, 5'b01000, 0, 5'b01000, A, 5'b10111, X, X, X, X, X));
    tbl.push_back(mk(0, 0, 0, 5'b01000, 0, 5'b01000, A, A, X, X, X, 4, X));
    tbl.push_back(mk(0, 0, 0, 5'b01000, 0, 0, A, 5'b10111, X, X, X, X, X));
    tbl.push_back(mk(0, 0, 0, 5'b01000, 0, 0, A, A, X, X, X, 2, X));
    // multi-bit request: input 4 only counts for output 1; input 3 gets output 3
    tbl.push_back(mk(0, 0, 0, 0, 5'b01000, 5'b01010, A, A, X, 4, X, 3, X));

    for (int k = 0; k < tbl.size(); k++) apply(tbl[k], k);

    // packet on output 0: input 1 sends 3 flits (tail last), input 2 competes
`ifdef NW_SW_ALLOC_PKT_LOCK_EN
    apply(mk(0, 0, 5'b00001, 0, 0, 0, 5'b11101, A, 1, X, X, X, X), 100);
    apply(mk(0, 0, 0, 5'b00001, 0, 0, 5'b11101, A, X, X, X, X, X), 101);  // owner idle
    apply(mk(0, 0, 5'b00001, 5'b00001, 0, 0, 5'b11101, A, 1, X, X, X, X), 102);
    apply(mk(0, 0, 5'b00001, 5'b00001, 0, 0, A, A, 1, X, X, X, X), 103);
    apply(mk(0, 0, 5'b00001, 5'b00001, 0, 0, A, A, 2, X, X, X, X), 104);
`else
    apply(mk(0, 0, 5'b00001, 0, 0, 0, 5'b11101, A, 1, X, X, X, X), 100);
    apply(mk(0, 0, 0, 5'b00001, 0, 0, 5'b11101, A, 2, X, X, X, X), 101);
    apply(mk(0, 0, 5'b00001, 5'b00001, 0, 0, 5'b11101, A, 1, X, X, X, X), 102);
    apply(mk(0, 0, 5'b00001, 5'b00001, 0, 0, A, A, 2, X, X, X, X), 103);
    apply(mk(0, 0, 5'b00001, 5'b00001, 0, 0, A, A, 1, X, X, X, X), 104);
`endif

    // reset mid-packet on output 4: input 3 starts a packet, reset, then ptr4=0 decides
    apply(mk(0, 0, 0, 0, 5'b10000, 0, 5'b10111, A, X, X, X, X, 3), 200);
    apply(mk(1, 5'b10000, 0, 0, 5'b10000, 5'b10000, 5'b10111, A, X, X, X, X, X), 201);
    apply(mk(1, 5'b10000, 0, 0, 5'b10000, 5'b10000, 5'b10111, A, X, X, X, X, X), 202);
    apply(mk(0, 5'b10000, 0, 0, 5'b10000, 5'b10000, 5'b10111, A, X, X, X, X, 0), 203);
    apply(mk(0, 5'b10000, 0, 0, 5'b10000, 5'b10000, A, A, X, X, X, X, 3), 204);
    apply(mk(0, 0, 0, 0, 0, 0, A, A, X, X, X, X, X), 205);

    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL scoreboard: %0d left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
